// File: rtl/prio_sel_reg_if.sv
// prio_sel_reg_if: select/candidate inputs and registered-output handshake of prio_sel_reg.
interface prio_sel_reg_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
  logic [N-1:0]       sel;
  logic [N*WIDTH-1:0] din;
  logic               out_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [IDX_W-1:0]   out_idx;
  logic [N-1:0]       ack;
  logic [CNT_W-1:0]   stall_cnt;
  modport master (
    output sel, din, out_ready,
    input  out_valid, out_data, out_idx, ack, stall_cnt
  );
  modport slave (
    input  sel, din, out_ready,
    output out_valid, out_data, out_idx, ack, stall_cnt
  );
endinterface

// File: rtl/prio_sel_reg.sv
// prio_sel_reg: N-way priority select into a valid/ready output register with stall counter.
// Define PRIO_SEL_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module prio_sel_reg #(
  parameter int               WIDTH       = 4,
  parameter int               N           = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter logic [WIDTH-1:0] RST_VAL     = WIDTH'(4'hE),
  parameter int               CNT_W       = 8
) (
  input logic            clk,
  input logic            rst,
  prio_sel_reg_if.slave  bus
);
  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] w;
  logic             load, hit;
  assign load = !valid_q || bus.out_ready;
  assign hit  = |bus.sel;
`ifdef PRIO_SEL_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               j;
  // Scan from the farthest position back toward ptr so the nearest requester wins.
  always_comb begin
    w = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      j = (j >= N) ? j - N : j;
      if (bus.sel[IDX_W'(j)]) w = IDX_W'(j);
    end
  end
  assign ptr_d = (load && hit) ? ((w == IDX_W'(N - 1)) ? '0 : w + 1'b1) : ptr_q;
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
`else
  always_comb begin
    w = '0;
    for (int k = N - 1; k >= 0; k--)
      if (bus.sel[k]) w = IDX_W'(k);
  end
`endif
  always_comb begin
    valid_d = load ? hit : valid_q;
    data_d  = load ? (hit ? bus.din[w*WIDTH +: WIDTH] : DEFAULT_VAL) : data_q;
    idx_d   = load ? (hit ? w : '0) : idx_q;
    cnt_d   = (valid_q && !bus.out_ready && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.ack       = (!rst && load && hit) ? (N'(1) << w) : '0;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_prio_sel_reg.sv
// tb_prio_sel_reg: directed vectors for prio_sel_reg with hand-computed expectations.
module tb_prio_sel_reg;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  prio_sel_reg_if #(.WIDTH(4), .N(4), .CNT_W(3)) bus ();
  prio_sel_reg #(
    .WIDTH(4), .N(4), .DEFAULT_VAL(4'h1), .RST_VAL(4'hE), .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic capture(input logic [3:0] s, input logic [31:0] exp_idx, input logic [31:0] exp_data);
    bus.sel = s;
    bus.out_ready = 1'b1;
    #1;
    chk("cap_ack", bus.ack, 32'(4'b0001 << exp_idx));
    tick;
    chk("cap_valid", bus.out_valid, 1);
    chk("cap_idx", bus.out_idx, exp_idx);
    chk("cap_data", bus.out_data, exp_data);
  endtask
  initial begin
    rst = 1'b1;
    bus.sel = 4'b1111;
    bus.din = {4'h4, 4'h3, 4'h2, 4'h7};
    bus.out_ready = 1'b0;
    tick;
    tick;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 4'hE);
    chk("rst_cnt", bus.stall_cnt, 0);
    chk("rst_ack", bus.ack, 0);
    rst = 1'b0;
    bus.sel = 4'b0000;
    tick;
    chk("dflt_data", bus.out_data, 4'h1);
    chk("dflt_valid", bus.out_valid, 0);
    capture(4'b0110, 1, 4'h2);
    capture(4'b1000, 3, 4'h4);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sel = 4'(i + 1);
      bus.din = {4'hA, 4'hB, 4'hC, 4'(i)};
      #1;
      chk("stall_ack", bus.ack, 0);
      tick;
    end
    chk("stall_data", bus.out_data, 4'h4);
    chk("stall_idx", bus.out_idx, 3);
    chk("stall_cnt5", bus.stall_cnt, 5);
    bus.din = {4'h4, 4'h3, 4'h2, 4'h7};
    capture(4'b0001, 0, 4'h7);
    chk("cnt_hold", bus.stall_cnt, 5);
    bus.out_ready = 1'b0;
    tick;
    chk("cnt_6", bus.stall_cnt, 6);
    for (int i = 0; i < 9; i++) tick;
    chk("cnt_sat", bus.stall_cnt, 7);
    chk("sat_valid", bus.out_valid, 1);
    bus.sel = 4'b0000;
    bus.out_ready = 1'b1;
    #1;
    chk("idle_ack", bus.ack, 0);
    tick;
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_data", bus.out_data, 4'h1);
    chk("idle_idx", bus.out_idx, 0);
    capture(4'b0100, 2, 4'h3);
    bus.out_ready = 1'b0;
    tick;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.sel = 4'b0010;
    #1;
    chk("mid_rst_ack", bus.ack, 0);
    tick;
    rst = 1'b0;
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_data", bus.out_data, 4'hE);
    chk("mid_cnt", bus.stall_cnt, 0);
    chk("mid_idx", bus.out_idx, 0);
`ifdef PRIO_SEL_ROUND_ROBIN_EN
    capture(4'b1111, 0, 4'h7);
    capture(4'b1111, 1, 4'h2);
    capture(4'b1111, 2, 4'h3);
    capture(4'b1111, 3, 4'h4);
    capture(4'b1111, 0, 4'h7);
    capture(4'b1001, 3, 4'h4);
    capture(4'b1001, 0, 4'h7);
`else
    capture(4'b1111, 0, 4'h7);
    capture(4'b1111, 0, 4'h7);
    capture(4'b1001, 0, 4'h7);
    capture(4'b1000, 3, 4'h4);
    capture(4'b1100, 2, 4'h3);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
